// File: rtl/usb_stream_ctrl.sv
// FX3 slave-FIFO master: streams header-tagged image lines and serves host command packets.
// Build option: define USB_TEST_PATTERN_EN to replace FIFO payload with a generated pattern.
module usb_stream_ctrl #(
  parameter int DQ_W       = 16,
  parameter int IM_X       = 1280,
  parameter int IM_Y       = 720,
  parameter int COLOR_MODE = 2,
  parameter int RD_LAT     = 4,
  parameter int WM_LAT     = 6,
  parameter int USEDW_W    = 12
) (
  input  logic               USB_CLK,
  input  logic               rst,
  input  logic               DMA0_Ready,
  input  logic               DMA0_Watermark,
  input  logic               DMA1_Ready,
  input  logic               DMA1_Watermark,
  output logic               WR,
  output logic               RD,
  output logic               OE,
  output logic               LastWRData,
  output logic [DQ_W-1:0]    DQ_out,
  output logic               DQ_oe,
  input  logic [DQ_W-1:0]    DQ_in,
  input  logic [DQ_W-1:0]    fifo_rdata,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic               start_stream,
  output logic [15:0]        frame_cnt
);

  localparam int          WORDS     = COLOR_MODE * IM_X * 8 / DQ_W + 1;
  localparam logic [15:0] LAST_IDX  = 16'(WORDS - 1);
  localparam logic [15:0] LAST_LINE = 16'(IM_Y - 1);
  localparam logic [31:0] LINE_NEED = 32'(WORDS - 1);

  typedef enum logic [3:0] {
    WAIT4DMA, WRITE, PAUSE_W, DR_READ, READ, PAUSE_R,
    RD_CMD, SEND_CFG, START_ST, STP_ST, RST_CNT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]      syncA_q, syncB_q;
  logic            d0Rdy, d0Wm, d1Rdy, d1Wm;
  logic [15:0]     sendCnt_q, sendCnt_d;
  logic [15:0]     lineCnt_q, lineCnt_d;
  logic [15:0]     frameCnt_q, frameCnt_d;
  logic [7:0]      latCnt_q, latCnt_d;
  logic [7:0]      cmd_q;
  logic [1:0]      cfgIdx_q, cfgIdx_d;
  logic            startStream_q, startStream_d;
  logic            stopPend_q, stopPend_d;
  logic            rstPend_q, rstPend_d;
  logic            wr_q, rd_q, oe_q, last_q;
  logic [DQ_W-1:0] dq_q, dq_d, cfgWord;
  logic            lineEnd, lineReady, midLine;
  logic            unusedDqIn;

  assign {d1Wm, d1Rdy, d0Wm, d0Rdy} = syncB_q;
  assign unusedDqIn = ^DQ_in[DQ_W-1:8];

  assign lineEnd = (state_q == WRITE) && (sendCnt_q == LAST_IDX);
  assign midLine = (sendCnt_q != 16'd0);

`ifdef USB_TEST_PATTERN_EN
  logic unusedUsedw;
  assign unusedUsedw = ^fifo_usedw;
  assign lineReady   = 1'b1;
  assign fifo_rdreq  = 1'b0;
`else
  assign lineReady  = 32'(fifo_usedw) >= LINE_NEED;
  assign fifo_rdreq = (state_q == WRITE) && (sendCnt_q != 16'd0) &&
                      (sendCnt_q <= LAST_IDX) && (fifo_usedw != '0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT4DMA: begin
        if (d1Rdy) state_d = DR_READ;
        else if (d0Rdy && startStream_q && (lineReady || midLine)) state_d = WRITE;
      end
      WRITE: begin
        if (d0Wm) state_d = PAUSE_W;
        else if (sendCnt_q == LAST_IDX) state_d = WAIT4DMA;
      end
      PAUSE_W:  if (!d0Rdy || latCnt_q == 8'(WM_LAT)) state_d = WAIT4DMA;
      DR_READ:  if (latCnt_q == 8'(RD_LAT)) state_d = READ;
      READ:     if (d1Wm) state_d = PAUSE_R;
      PAUSE_R:  if (!d1Rdy) state_d = RD_CMD;
      RD_CMD: begin
        case (cmd_q)
          8'h01:   if (d0Rdy && !d0Wm) state_d = SEND_CFG;
          8'h11:   state_d = START_ST;
          8'h0F:   state_d = STP_ST;
          8'h22:   state_d = RST_CNT;
          default: state_d = WAIT4DMA;
        endcase
      end
      SEND_CFG: if (cfgIdx_q == 2'd3) state_d = WAIT4DMA;
      default:  state_d = WAIT4DMA;
    endcase
  end

  // Stop and counter reset requested mid-line are held until the line's last word.
  always_comb begin
    sendCnt_d     = sendCnt_q;
    lineCnt_d     = lineCnt_q;
    frameCnt_d    = frameCnt_q;
    startStream_d = startStream_q;
    stopPend_d    = stopPend_q;
    rstPend_d     = rstPend_q;
    latCnt_d      = 8'd0;
    cfgIdx_d      = 2'd0;
    if ((state_q == PAUSE_W || state_q == DR_READ) && state_d == state_q)
      latCnt_d = latCnt_q + 8'd1;
    if (state_q == SEND_CFG)
      cfgIdx_d = cfgIdx_q + 2'd1;
    if (state_q == WRITE)
      sendCnt_d = lineEnd ? 16'd0 : sendCnt_q + 16'd1;
    if (lineEnd) begin
      if (lineCnt_q == LAST_LINE) begin
        lineCnt_d  = 16'd0;
        frameCnt_d = frameCnt_q + 16'd1;
      end else begin
        lineCnt_d = lineCnt_q + 16'd1;
      end
      if (stopPend_q) begin
        startStream_d = 1'b0;
        stopPend_d    = 1'b0;
      end
      if (rstPend_q) begin
        lineCnt_d  = 16'd0;
        frameCnt_d = 16'd0;
        rstPend_d  = 1'b0;
      end
    end
    case (state_q)
      START_ST: begin
        startStream_d = 1'b1;
        lineCnt_d     = 16'd0;
      end
      STP_ST: begin
        if (midLine) stopPend_d = 1'b1;
        else startStream_d = 1'b0;
      end
      RST_CNT: begin
        if (midLine) begin
          rstPend_d = 1'b1;
        end else begin
          lineCnt_d  = 16'd0;
          frameCnt_d = 16'd0;
        end
      end
      default: ;
    endcase
    if (!startStream_q) lineCnt_d = 16'd0;
  end

  always_comb begin
    cfgWord = '0;
    case (cfgIdx_q)
      2'd0:    cfgWord = DQ_W'((COLOR_MODE == 1) ? 16'h00AA : 16'h00BB);
      2'd1:    cfgWord = DQ_W'(16'(IM_X));
      2'd2:    cfgWord = DQ_W'(16'(IM_Y));
      default: cfgWord = DQ_W'(frameCnt_q);
    endcase
  end

  // Header is line_cnt on a 16-bit bus and {frame_cnt, line_cnt} on a 32-bit bus.
  always_comb begin
    dq_d = fifo_rdata;
    if (state_q == SEND_CFG)
      dq_d = cfgWord;
    else if ((state_q == WRITE || state_q == PAUSE_W) && !midLine)
      dq_d = DQ_W'({frameCnt_q, lineCnt_q});
`ifdef USB_TEST_PATTERN_EN
    else if (state_q == WRITE)
      dq_d = {(DQ_W/16){lineCnt_q[7:0], sendCnt_q[7:0]}};
`endif
  end

  always_ff @(posedge USB_CLK) begin
    if (rst) begin
      state_q       <= WAIT4DMA;
      syncA_q       <= '0;
      syncB_q       <= '0;
      sendCnt_q     <= '0;
      lineCnt_q     <= '0;
      frameCnt_q    <= '0;
      latCnt_q      <= '0;
      cmd_q         <= '0;
      cfgIdx_q      <= '0;
      startStream_q <= 1'b0;
      stopPend_q    <= 1'b0;
      rstPend_q     <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      oe_q          <= 1'b0;
      last_q        <= 1'b0;
      dq_q          <= '0;
    end else begin
      state_q       <= state_d;
      syncA_q       <= {DMA1_Watermark, DMA1_Ready, DMA0_Watermark, DMA0_Ready};
      syncB_q       <= syncA_q;
      sendCnt_q     <= sendCnt_d;
      lineCnt_q     <= lineCnt_d;
      frameCnt_q    <= frameCnt_d;
      latCnt_q      <= latCnt_d;
      cfgIdx_q      <= cfgIdx_d;
      startStream_q <= startStream_d;
      stopPend_q    <= stopPend_d;
      rstPend_q     <= rstPend_d;
      if (state_q == READ) cmd_q <= DQ_in[7:0];
      wr_q          <= (state_q == WRITE) || (state_q == SEND_CFG);
      rd_q          <= (state_q == DR_READ) && (latCnt_q == 8'd1);
      oe_q          <= (state_q == DR_READ) || (state_q == READ);
      last_q        <= (state_q == SEND_CFG) && (cfgIdx_q == 2'd3);
      dq_q          <= dq_d;
    end
  end

  assign WR           = wr_q;
  assign DQ_oe        = wr_q;
  assign RD           = rd_q;
  assign OE           = oe_q;
  assign LastWRData   = last_q;
  assign DQ_out       = dq_q;
  assign start_stream = startStream_q;
  assign frame_cnt    = frameCnt_q;

endmodule

// File: tb/tb_usb_stream_ctrl.sv
// Scoreboard bench for usb_stream_ctrl: 16-bit bus, 8-pixel lines, 2-line frames.
module tb_usb_stream_ctrl;

  localparam int DQ_W       = 16;
  localparam int IM_X       = 8;
  localparam int IM_Y       = 2;
  localparam int COLOR_MODE = 2;
  localparam int RD_LAT     = 4;
  localparam int WM_LAT     = 6;
  localparam int USEDW_W    = 12;

  logic               USB_CLK = 1'b0;
  logic               rst = 1'b1;
  logic               DMA0_Ready = 1'b0, DMA0_Watermark = 1'b0;
  logic               DMA1_Ready = 1'b0, DMA1_Watermark = 1'b0;
  logic               WR, RD, OE, LastWRData, DQ_oe, fifo_rdreq, start_stream;
  logic [DQ_W-1:0]    DQ_out, fifo_rdata;
  logic [DQ_W-1:0]    DQ_in = '0;
  logic [USEDW_W-1:0] fifo_usedw;
  logic [15:0]        frame_cnt;

  usb_stream_ctrl #(
    .DQ_W(DQ_W), .IM_X(IM_X), .IM_Y(IM_Y), .COLOR_MODE(COLOR_MODE),
    .RD_LAT(RD_LAT), .WM_LAT(WM_LAT), .USEDW_W(USEDW_W)
  ) dut (
    .USB_CLK(USB_CLK), .rst(rst),
    .DMA0_Ready(DMA0_Ready), .DMA0_Watermark(DMA0_Watermark),
    .DMA1_Ready(DMA1_Ready), .DMA1_Watermark(DMA1_Watermark),
    .WR(WR), .RD(RD), .OE(OE), .LastWRData(LastWRData),
    .DQ_out(DQ_out), .DQ_oe(DQ_oe), .DQ_in(DQ_in),
    .fifo_rdata(fifo_rdata), .fifo_usedw(fifo_usedw), .fifo_rdreq(fifo_rdreq),
    .start_stream(start_stream), .frame_cnt(frame_cnt)
  );

  always #5 USB_CLK = ~USB_CLK;

  // Show-ahead upstream FIFO model; flushed by reset.
  logic [15:0] fifoMem [0:63];
  int fifoWp = 0;
  int fifoRp = 0;
  int popCount = 0;
  assign fifo_rdata = fifoMem[fifoRp[5:0]];
  assign fifo_usedw = USEDW_W'(fifoWp - fifoRp);

  always @(posedge USB_CLK) begin
    if (rst) fifoRp <= fifoWp;
    else if (fifo_rdreq) begin
      fifoRp   <= fifoRp + 1;
      popCount <= popCount + 1;
    end
  end

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } expWord_t;

  expWord_t expQ[$];
  int checks = 0;
  int failures = 0;
  int rdCount = 0;
  int wrBursts = 0;
  logic prevWr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every bus write must match the next queued expectation.
  always @(negedge USB_CLK) begin : monitor
    expWord_t e;
    if (!rst) begin
      if (RD) rdCount <= rdCount + 1;
      if (prevWr && !WR) wrBursts <= wrBursts + 1;
      prevWr <= WR;
      if (WR) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected write: DQ_out=0x%0h, expected no write", DQ_out);
        end else begin
          e = expQ.pop_front();
          checkOutput("DQ_out word", 32'(DQ_out), 32'(e.data));
          checkOutput("LastWRData", 32'(LastWRData), 32'(e.last));
          checkOutput("DQ_oe", 32'(DQ_oe), 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge USB_CLK);
    #1;
  endtask

  task automatic preloadLine(input logic [15:0] base, input logic [15:0] header);
    expQ.push_back('{data: header, last: 1'b0});
    for (int i = 0; i < 8; i++) begin
      fifoMem[fifoWp[5:0]] = base + 16'(i);
      fifoWp = fifoWp + 1;
      expQ.push_back('{data: base + 16'(i), last: 1'b0});
    end
  endtask

  task automatic pushCfg(input logic [15:0] frame);
    expQ.push_back('{data: 16'h00BB, last: 1'b0});
    expQ.push_back('{data: 16'h0008, last: 1'b0});
    expQ.push_back('{data: 16'h0002, last: 1'b0});
    expQ.push_back('{data: frame, last: 1'b1});
  endtask

  task automatic waitWr(input string name);
    int n;
    n = 0;
    while (WR !== 1'b1 && n < 64) begin
      @(negedge USB_CLK);
      n++;
    end
    if (WR !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: WR stayed 0, expected 1 within 64 cycles", name);
    end
  endtask

  // One host packet over DMA1: ready, wait for the read window, watermark, release.
  task automatic applyStimulus(input logic [7:0] code);
    int n;
    int rdBefore;
    rdBefore   = rdCount;
    DQ_in      = {8'h00, code};
    DMA1_Ready = 1'b1;
    n = 0;
    while (OE !== 1'b1 && n < 64) begin
      @(negedge USB_CLK);
      n++;
    end
    if (OE !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd 0x%0h: OE stayed 0, expected 1 within 64 cycles", code);
    end
    tick(8);
    DMA1_Watermark = 1'b1;
    tick(1);
    DMA1_Watermark = 1'b0;
    DMA1_Ready     = 1'b0;
    tick(6);
    checkOutput("RD pulses per command", 32'(rdCount - rdBefore), 32'd1);
  endtask

  initial begin : stimulus
    int popBase;
    int burstBase;
    for (int i = 0; i < 64; i++) fifoMem[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge USB_CLK);
    @(negedge USB_CLK);
    checkOutput("reset WR", 32'(WR), 32'd0);
    checkOutput("reset RD", 32'(RD), 32'd0);
    checkOutput("reset OE", 32'(OE), 32'd0);
    checkOutput("reset LastWRData", 32'(LastWRData), 32'd0);
    checkOutput("reset DQ_out", 32'(DQ_out), 32'd0);
    checkOutput("reset start_stream", 32'(start_stream), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset fifo_rdreq", 32'(fifo_rdreq), 32'd0);
    @(posedge USB_CLK);
    #1;
    rst = 1'b0;
    DMA0_Ready = 1'b1;
    tick(4);

    // Config request before streaming starts.
    pushCfg(16'd0);
    applyStimulus(8'h01);
    tick(6);

    applyStimulus(8'h11);
    checkOutput("start_stream after START", 32'(start_stream), 32'd1);

    // Line 0: a single uninterrupted 9-word burst.
    popBase   = popCount;
    burstBase = wrBursts;
    preloadLine(16'h1000, 16'h0000);
    waitWr("line0 start");
    tick(16);
    checkOutput("line0 pops", 32'(popCount - popBase), 32'd8);
    checkOutput("line0 bursts", 32'(wrBursts - burstBase), 32'd1);

    // Line 1: watermark pause mid-line, resume without loss; frame wraps.
    burstBase = wrBursts;
    preloadLine(16'h2000, 16'h0001);
    waitWr("line1 start");
    DMA0_Watermark = 1'b1;
    tick(1);
    DMA0_Watermark = 1'b0;
    tick(30);
    checkOutput("line1 bursts", 32'(wrBursts - burstBase), 32'd2);
    checkOutput("frame_cnt after wrap", 32'(frame_cnt), 32'd1);

    pushCfg(16'd1);
    applyStimulus(8'h01);
    tick(6);

    // Line 2: STOP lands while the line is paused; line must still complete.
    burstBase = wrBursts;
    preloadLine(16'h3000, 16'h0000);
    waitWr("line2 start");
    DMA0_Watermark = 1'b1;
    tick(1);
    DMA0_Watermark = 1'b0;
    applyStimulus(8'h0F);
    checkOutput("start_stream held mid-line", 32'(start_stream), 32'd1);
    tick(12);
    checkOutput("start_stream after stop", 32'(start_stream), 32'd0);
    checkOutput("line2 bursts", 32'(wrBursts - burstBase), 32'd2);
    checkOutput("frame_cnt after stop", 32'(frame_cnt), 32'd1);

    applyStimulus(8'h22);
    checkOutput("frame_cnt after RST_CNT", 32'(frame_cnt), 32'd0);

    // Restart: line counter begins at 0 again.
    applyStimulus(8'h11);
    preloadLine(16'h4000, 16'h0000);
    waitWr("line3 start");
    tick(16);
    preloadLine(16'h5000, 16'h0001);
    waitWr("line4 start");
    tick(16);
    checkOutput("frame_cnt second frame", 32'(frame_cnt), 32'd1);

    // Reset in the middle of a write burst.
    preloadLine(16'h6000, 16'h0000);
    waitWr("line5 start");
    tick(1);
    rst = 1'b1;
    tick(1);
    expQ.delete();
    @(negedge USB_CLK);
    checkOutput("mid-write reset WR", 32'(WR), 32'd0);
    checkOutput("mid-write reset DQ_out", 32'(DQ_out), 32'd0);
    checkOutput("mid-write reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mid-write reset start_stream", 32'(start_stream), 32'd0);
    @(posedge USB_CLK);
    #1;
    rst = 1'b0;
    tick(8);
    checkOutput("idle after reset WR", 32'(WR), 32'd0);

    pushCfg(16'd0);
    applyStimulus(8'h01);
    tick(8);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
